// File: rtl/sprite_addr_gen_pkg.sv
// Shared game constants for the player sprite, life icons and sprite ROM,
// plus the invulnerability state encoding and a small width helper.
package sprite_addr_gen_pkg;

   // Default geometry shared by the ROM init, the pixel mux and this block
   localparam int SPR_W_DEF     = 32;
   localparam int SPR_H_DEF     = 32;
   localparam int X_OFF_DEF     = 160;
   localparam int LIFE_Y_DEF    = 448;
   localparam int MAX_LIVES_DEF = 3;

   // Invulnerability state machine encoding
   typedef enum logic [0:0] {
      INV_IDLE   = 1'b0,
      INV_ACTIVE = 1'b1
   } inv_state_t;

   // Counter width for a modulus, never narrower than one bit
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation frame sequencing and post-hit invulnerability / blink control.
// All state advances on frame_tick; a hit restarts the invulnerability window.
module sprite_anim_ctrl
   import sprite_addr_gen_pkg::*;
#(
   parameter int N_FRAMES   = 4,
   parameter int FRAME_DIV  = 8,
   parameter int INV_FRAMES = 60,
   parameter int BLINK_DIV  = 4,
   parameter int FRAME_W    = clog2_min1(N_FRAMES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               hit,
   output logic [FRAME_W-1:0] frame_idx,
   output logic               hide,
   output logic               invuln
);

   localparam int DIV_W   = clog2_min1(FRAME_DIV);
   localparam int INV_W   = clog2_min1(INV_FRAMES);
   localparam int BLINK_W = clog2_min1(BLINK_DIV);

   logic [DIV_W-1:0]   div_cnt_reg;
   logic [FRAME_W-1:0] frame_idx_reg;

   inv_state_t         state_reg, state_next;
   logic [INV_W-1:0]   inv_cnt_reg, inv_cnt_next;
   logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
   logic               phase_reg, phase_next;

   // Divide frame ticks down to animation steps and cycle the frame index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt_reg   <= '0;
         frame_idx_reg <= '0;
      end else if (frame_tick) begin
         if (div_cnt_reg == DIV_W'(FRAME_DIV - 1)) begin
            div_cnt_reg <= '0;
            if (frame_idx_reg == FRAME_W'(N_FRAMES - 1))
               frame_idx_reg <= '0;
            else
               frame_idx_reg <= frame_idx_reg + FRAME_W'(1);
         end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
         end
      end
   end

   assign frame_idx = frame_idx_reg;

   // Invulnerability state, remaining-tick counter and blink phase registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= INV_IDLE;
         inv_cnt_reg   <= '0;
         blink_cnt_reg <= '0;
         phase_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         inv_cnt_reg   <= inv_cnt_next;
         blink_cnt_reg <= blink_cnt_next;
         phase_reg     <= phase_next;
      end
   end

   // Next-state logic: a hit (re)starts the window and the blink phase, and
   // takes precedence over a simultaneous tick so no tick is consumed
   always_comb begin
      state_next     = state_reg;
      inv_cnt_next   = inv_cnt_reg;
      blink_cnt_next = blink_cnt_reg;
      phase_next     = phase_reg;
      invuln         = 1'b0;
      hide           = 1'b0;
      case (state_reg)
         INV_IDLE: begin
            if (hit) begin
               state_next     = INV_ACTIVE;
               inv_cnt_next   = INV_W'(INV_FRAMES - 1);
               blink_cnt_next = '0;
               phase_next     = 1'b0;
            end
         end
         INV_ACTIVE: begin
            invuln = 1'b1;
            hide   = phase_reg;
            if (hit) begin
               inv_cnt_next   = INV_W'(INV_FRAMES - 1);
               blink_cnt_next = '0;
               phase_next     = 1'b0;
            end else if (frame_tick) begin
               if (inv_cnt_reg == '0) begin
                  state_next = INV_IDLE;
               end else begin
                  inv_cnt_next = inv_cnt_reg - INV_W'(1);
                  if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
                     blink_cnt_next = '0;
                     phase_next     = ~phase_reg;
                  end else begin
                     blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
                  end
               end
            end
         end
         default: begin
            state_next = INV_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/sprite_addr_gen.sv
// Player sprite and life-icon ROM address generator. Player state is latched
// once per frame so the sprite never tears; a two-stage pipeline turns the
// scan position into a registered ROM address and valid flag.
module sprite_addr_gen
   import sprite_addr_gen_pkg::*;
#(
   parameter int SPR_W      = SPR_W_DEF,
   parameter int SPR_H      = SPR_H_DEF,
   parameter int N_FRAMES   = 4,
   parameter int FRAME_DIV  = 8,
   parameter int X_OFF      = X_OFF_DEF,
   parameter int LIFE_Y     = LIFE_Y_DEF,
   parameter int MAX_LIVES  = MAX_LIVES_DEF,
   parameter int INV_FRAMES = 60,
   parameter int BLINK_DIV  = 4,
   parameter int ADDR_W     = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_tick,
   input  logic              me_vi,
   input  logic [2:0]        me_lifes,
   input  logic [8:0]        me_x,
   input  logic [8:0]        me_y,
   input  logic              hit,
   input  logic [9:0]        h_cnt,
   input  logic [9:0]        v_cnt,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic              pixel_valid,
   output logic              invuln
);

   localparam int FRAME_W    = clog2_min1(N_FRAMES);
   localparam int COL_W      = clog2_min1(SPR_W);
   localparam int ROW_W      = clog2_min1(SPR_H);
   localparam int N_ICONS    = MAX_LIVES - 1;
   localparam int ICON_VEC_W = (N_ICONS > 0) ? N_ICONS : 1;

   localparam logic [2:0]  LIVES_CAP   = 3'(MAX_LIVES);
   localparam logic [10:0] LIFE_Y0     = 11'(LIFE_Y);
   localparam logic [10:0] LIFE_Y1     = 11'(LIFE_Y + SPR_H);
   localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SPR_W * SPR_H);
   localparam logic [ADDR_W-1:0] ROW_WORDS   = ADDR_W'(SPR_W);

   // Per-frame shadow copies of the player state
   logic [8:0] x_l_reg, y_l_reg;
   logic       me_vi_l_reg;
   logic [2:0] lives_l_reg;
   logic [2:0] lives_clamped;

   logic [FRAME_W-1:0] frame_idx;
   logic               hide;

   // Window compare signals (11-bit so right/bottom edges never wrap)
   logic [10:0] h_ext, v_ext;
   logic [10:0] body_x0, body_x1, body_y0, body_y1;
   logic        body_hit;
   logic [COL_W-1:0] body_col;
   logic [ROW_W-1:0] body_row;
   logic        icon_v_hit;
   logic [ROW_W-1:0] icon_row;
   logic [ICON_VEC_W-1:0] icon_hit;
   logic [COL_W-1:0] icon_col [ICON_VEC_W];

   // Stage 1 and stage 2 pipeline registers
   logic               s1_valid_reg, s1_valid_next;
   logic [FRAME_W-1:0] s1_frame_reg, s1_frame_next;
   logic [ROW_W-1:0]   s1_row_reg, s1_row_next;
   logic [COL_W-1:0]   s1_col_reg, s1_col_next;
   logic [ADDR_W-1:0]  pixel_addr_reg, pixel_addr_next;
   logic               pixel_valid_reg;

   sprite_anim_ctrl #(
      .N_FRAMES   (N_FRAMES),
      .FRAME_DIV  (FRAME_DIV),
      .INV_FRAMES (INV_FRAMES),
      .BLINK_DIV  (BLINK_DIV),
      .FRAME_W    (FRAME_W)
   ) u_anim (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .hit        (hit),
      .frame_idx  (frame_idx),
      .hide       (hide),
      .invuln     (invuln)
   );

   assign lives_clamped = (me_lifes > LIVES_CAP) ? LIVES_CAP : me_lifes;

   // Latch player position, visibility and clamped lives once per frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_l_reg     <= '0;
         y_l_reg     <= '0;
         me_vi_l_reg <= 1'b0;
         lives_l_reg <= '0;
      end else if (frame_tick) begin
         x_l_reg     <= me_x;
         y_l_reg     <= me_y;
         me_vi_l_reg <= me_vi;
         lives_l_reg <= lives_clamped;
      end
   end

   assign h_ext   = {1'b0, h_cnt};
   assign v_ext   = {1'b0, v_cnt};
   assign body_x0 = 11'(X_OFF) + {2'b00, x_l_reg};
   assign body_x1 = body_x0 + 11'(SPR_W);
   assign body_y0 = {2'b00, y_l_reg};
   assign body_y1 = body_y0 + 11'(SPR_H);

   assign body_hit = me_vi_l_reg && !hide &&
                     (h_ext >= body_x0) && (h_ext < body_x1) &&
                     (v_ext >= body_y0) && (v_ext < body_y1);
   assign body_col = COL_W'(h_ext - body_x0);
   assign body_row = ROW_W'(v_ext - body_y0);

   assign icon_v_hit = (v_ext >= LIFE_Y0) && (v_ext < LIFE_Y1);
   assign icon_row   = ROW_W'(v_ext - LIFE_Y0);

   // One compare per life icon; icon k is shown only while k+1 < lives
   generate
      if (N_ICONS > 0) begin : g_icons
         for (genvar gi = 0; gi < N_ICONS; gi++) begin : g_icon
            localparam logic [10:0] ICON_X0 = 11'(X_OFF + gi * SPR_W);
            localparam logic [10:0] ICON_X1 = 11'(X_OFF + (gi + 1) * SPR_W);
            assign icon_hit[gi] = icon_v_hit && (lives_l_reg > 3'(gi + 1)) &&
                                  (h_ext >= ICON_X0) && (h_ext < ICON_X1);
            assign icon_col[gi] = COL_W'(h_ext - ICON_X0);
         end
      end else begin : g_no_icons
         assign icon_hit    = '0;
         assign icon_col[0] = '0;
      end
   endgenerate

   // Select the winning window: the body has priority over the icons
   always_comb begin
      s1_valid_next = 1'b0;
      s1_frame_next = '0;
      s1_row_next   = '0;
      s1_col_next   = '0;
      if (body_hit) begin
         s1_valid_next = 1'b1;
         s1_frame_next = frame_idx;
         s1_row_next   = body_row;
         s1_col_next   = body_col;
      end else begin
         for (int i = 0; i < N_ICONS; i++) begin
            if (icon_hit[i]) begin
               s1_valid_next = 1'b1;
               s1_row_next   = icon_row;
               s1_col_next   = icon_col[i];
            end
         end
      end
   end

   // Stage 1: register window result and offsets
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_frame_reg <= '0;
         s1_row_reg   <= '0;
         s1_col_reg   <= '0;
      end else begin
         s1_valid_reg <= s1_valid_next;
         s1_frame_reg <= s1_frame_next;
         s1_row_reg   <= s1_row_next;
         s1_col_reg   <= s1_col_next;
      end
   end

   // Frame base plus row-major offset; forced to zero outside any window
   always_comb begin
      pixel_addr_next = '0;
      if (s1_valid_reg) begin
         pixel_addr_next = ADDR_W'(s1_frame_reg) * FRAME_WORDS +
                           ADDR_W'(s1_row_reg) * ROW_WORDS +
                           ADDR_W'(s1_col_reg);
      end
   end

   // Stage 2: register the ROM address and valid flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pixel_addr_reg  <= '0;
         pixel_valid_reg <= 1'b0;
      end else begin
         pixel_addr_reg  <= pixel_addr_next;
         pixel_valid_reg <= s1_valid_reg;
      end
   end

   assign pixel_addr  = pixel_addr_reg;
   assign pixel_valid = pixel_valid_reg;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Self-checking bench for sprite_addr_gen: directed steps plus randomized
// scans compared against a behavioural model of the sprite rules.
module tb_sprite_addr_gen;

   localparam int SPR_W      = 32;
   localparam int SPR_H      = 32;
   localparam int N_FRAMES   = 4;
   localparam int FRAME_DIV  = 8;
   localparam int X_OFF      = 160;
   localparam int LIFE_Y     = 448;
   localparam int MAX_LIVES  = 3;
   localparam int INV_FRAMES = 60;
   localparam int BLINK_DIV  = 4;
   localparam int ADDR_W     = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              frame_tick;
   logic              me_vi;
   logic [2:0]        me_lifes;
   logic [8:0]        me_x, me_y;
   logic              hit;
   logic [9:0]        h_cnt, v_cnt;
   logic [ADDR_W-1:0] pixel_addr;
   logic              pixel_valid;
   logic              invuln;

   int checks = 0;
   int errors = 0;

   // Desired player state presented at the next frame tick
   int want_x, want_y, want_vi, want_lives;

   // Reference model state
   int m_x, m_y, m_vi, m_lives;
   int m_ticks;
   bit m_inv;
   int m_inv_ticks;

   sprite_addr_gen #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(N_FRAMES), .FRAME_DIV(FRAME_DIV),
      .X_OFF(X_OFF), .LIFE_Y(LIFE_Y), .MAX_LIVES(MAX_LIVES),
      .INV_FRAMES(INV_FRAMES), .BLINK_DIV(BLINK_DIV), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .me_vi(me_vi),
      .me_lifes(me_lifes), .me_x(me_x), .me_y(me_y), .hit(hit),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .pixel_addr(pixel_addr),
      .pixel_valid(pixel_valid), .invuln(invuln)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_x = 0; m_y = 0; m_vi = 0; m_lives = 0;
      m_ticks = 0; m_inv = 0; m_inv_ticks = 0;
   endtask

   // Expected output for a scan position under the current model state
   function automatic void model_pixel(input int h, input int v, output int addr, output bit valid);
      bit shown;
      valid = 0;
      addr  = 0;
      shown = (m_vi != 0) && !(m_inv && (((m_inv_ticks / BLINK_DIV) % 2) == 1));
      if (shown && h >= X_OFF + m_x && h < X_OFF + m_x + SPR_W && v >= m_y && v < m_y + SPR_H) begin
         valid = 1;
         addr  = ((m_ticks / FRAME_DIV) % N_FRAMES) * SPR_W * SPR_H
               + (v - m_y) * SPR_W + (h - X_OFF - m_x);
      end else if (v >= LIFE_Y && v < LIFE_Y + SPR_H && h >= X_OFF && h < X_OFF + (m_lives - 1) * SPR_W) begin
         valid = 1;
         addr  = (v - LIFE_Y) * SPR_W + (h - X_OFF) % SPR_W;
      end
   endfunction

   task automatic scramble_inputs();
      me_x     = 9'($urandom);
      me_y     = 9'($urandom);
      me_vi    = 1'($urandom);
      me_lifes = 3'($urandom);
   endtask

   // One vsync pulse (optionally with a hit) latching the desired player state
   task automatic tick(input bit with_hit);
      @(negedge clk);
      me_x = 9'(want_x); me_y = 9'(want_y); me_vi = 1'(want_vi); me_lifes = 3'(want_lives);
      frame_tick = 1'b1;
      hit        = with_hit;
      m_x = want_x; m_y = want_y; m_vi = want_vi;
      m_lives = (want_lives > MAX_LIVES) ? MAX_LIVES : want_lives;
      m_ticks++;
      if (with_hit) begin
         m_inv = 1; m_inv_ticks = 0;
      end else if (m_inv) begin
         m_inv_ticks++;
         if (m_inv_ticks >= INV_FRAMES) m_inv = 0;
      end
      @(negedge clk);
      frame_tick = 1'b0;
      hit        = 1'b0;
      chk("invuln_tick", 32'(invuln), 32'(m_inv));
      scramble_inputs();
   endtask

   task automatic hit_pulse();
      @(negedge clk);
      hit = 1'b1;
      m_inv = 1; m_inv_ticks = 0;
      @(negedge clk);
      hit = 1'b0;
      chk("invuln_hit", 32'(invuln), 32'(m_inv));
   endtask

   task automatic probe(input string tag, input int h, input int v, input int exp_addr, input bit exp_valid);
      @(negedge clk);
      h_cnt = 10'(h); v_cnt = 10'(v);
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(pixel_valid), 32'(exp_valid));
      chk({tag, "_addr"}, 32'(pixel_addr), 32'(exp_addr));
   endtask

   // Back-to-back pixels, each checked two cycles after it was presented
   // mode 0: around the body, 1: around the icon row, 2: anywhere
   task automatic scan(input int n, input int mode);
      int q_addr[$];
      bit q_valid[$];
      int h, v, ea;
      bit ev;
      for (int i = 0; i < n + 2; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            chk("scan_valid", 32'(pixel_valid), 32'(q_valid.pop_front()));
            chk("scan_addr", 32'(pixel_addr), 32'(q_addr.pop_front()));
         end
         if (i < n) begin
            case (mode)
               0: begin
                  h = X_OFF + m_x + int'($urandom_range(0, SPR_W + 7)) - 4;
                  v = m_y + int'($urandom_range(0, SPR_H + 7)) - 4;
               end
               1: begin
                  h = X_OFF + int'($urandom_range(0, MAX_LIVES * SPR_W + 8)) - 4;
                  v = LIFE_Y + int'($urandom_range(0, SPR_H + 3)) - 2;
               end
               default: begin
                  h = int'($urandom_range(0, 1023));
                  v = int'($urandom_range(0, 1023));
               end
            endcase
            if (h < 0) h = 0;
            if (h > 1023) h = 1023;
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            h_cnt = 10'(h); v_cnt = 10'(v);
            model_pixel(h, v, ea, ev);
            q_addr.push_back(ea);
            q_valid.push_back(ev);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; hit = 1'b0;
      me_vi = 1'b0; me_lifes = '0; me_x = '0; me_y = '0;
      h_cnt = '0; v_cnt = '0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_addr", 32'(pixel_addr), 32'd0);
      chk("rst_valid", 32'(pixel_valid), 32'd0);
      chk("rst_invuln", 32'(invuln), 32'd0);
      rst_n = 1'b1;
      scramble_inputs();

      // Nothing drawn before the first frame tick
      probe("pre_tick", 170, 20, 0, 0);
      probe("pre_tick_icon", 200, 450, 0, 0);

      // Body address
      want_x = 10; want_y = 20; want_vi = 1; want_lives = 3;
      tick(0);
      probe("body_first", 170, 20, 0, 1);
      probe("body_last", 201, 51, 1023, 1);
      probe("body_right", 202, 51, 0, 0);
      probe("body_above", 170, 19, 0, 0);
      scan(150, 0);
      scan(100, 1);
      scan(100, 2);

      // Animation stepping and wrap
      repeat (7) tick(0);
      probe("anim_f1", 170, 20, 1024, 1);
      scan(40, 0);
      repeat (24) tick(0);
      probe("anim_wrap", 170, 20, 0, 1);

      // No tearing: live inputs change, latched copy stays
      me_x = 9'd300;
      probe("tear_old", 170, 20, 0, 1);
      probe("tear_new", 460, 20, 0, 0);
      want_x = 300;
      tick(0);
      probe("tear_after", 460, 20, 0, 1);

      // Life icons
      want_lives = 3;
      tick(0);
      probe("icon0_first", 160, 448, 0, 1);
      probe("icon1_last", 223, 479, 1023, 1);
      probe("icon1_mid", 192, 450, 64, 1);
      probe("icon_past", 224, 448, 0, 0);
      scan(60, 1);
      want_lives = 7;
      tick(0);
      probe("icon_clamp", 223, 479, 1023, 1);
      probe("icon_clamp_past", 224, 448, 0, 0);
      scan(60, 1);
      want_lives = 1;
      tick(0);
      probe("icon_one_life", 160, 448, 0, 0);
      scan(60, 1);
      want_lives = 0;
      tick(0);
      scan(40, 1);

      // Body overlapping the icon row takes priority
      want_x = 20; want_y = 440; want_lives = 3;
      tick(0);
      scan(80, 1);

      // Randomized player states, including right/bottom edges
      for (int r = 0; r < 10; r++) begin
         want_x = int'($urandom_range(0, 511));
         want_y = int'($urandom_range(0, 511));
         want_vi = int'($urandom_range(0, 1));
         want_lives = int'($urandom_range(0, 7));
         if (r == 0) begin want_x = 511; want_y = 511; want_vi = 1; end
         tick(0);
         scan(40, 0);
         scan(20, 1);
      end

      // Invulnerability, blink and extension by a second hit
      want_x = 10; want_y = 20; want_vi = 1; want_lives = 3;
      tick(0);
      hit_pulse();
      chk("inv_on", 32'(invuln), 32'd1);
      for (int i = 0; i < 100; i++) begin
         scan(8, 0);
         tick(0);
         if (i == 29) hit_pulse();
      end
      chk("inv_end", 32'(invuln), 32'd0);

      // Hit coinciding with a frame tick reloads without consuming the tick
      hit_pulse();
      repeat (5) tick(0);
      tick(1);
      scan(8, 0);
      repeat (4) tick(0);
      probe("blink_hidden", X_OFF + 10, 20, 0, 0);
      scan(8, 0);
      chk("inv_still", 32'(invuln), 32'd1);

      // Reset mid-scan during invulnerability
      repeat (4) tick(0);
      @(negedge clk);
      h_cnt = 10'd170; v_cnt = 10'd20;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_addr", 32'(pixel_addr), 32'd0);
      chk("midrst_valid", 32'(pixel_valid), 32'd0);
      chk("midrst_invuln", 32'(invuln), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      probe("postrst_body", 170, 20, 0, 0);
      probe("postrst_icon", 170, 450, 0, 0);
      tick(0);
      probe("postrst_tick", 170, 20, 0, 1);
      repeat (3) tick(0);
      scan(40, 0);
      scan(40, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
